// File: rtl/im_fetch_ctrl_pkg.sv
// Shared CPU fetch constants, FSM state encoding and small helpers used by
// the fetch controller and the address-window checker.
package im_fetch_ctrl_pkg;

   localparam logic [31:0] CPU_RESET_PC  = 32'h0000_3000;
   localparam int unsigned CPU_IM_WORDS  = 65536;
   localparam logic [31:0] INSTR_BUBBLE  = 32'h0000_0000;
   localparam logic [31:0] PC_STEP       = 32'd4;

   typedef enum logic {
      FETCH_RUN    = 1'b0,
      FETCH_BUBBLE = 1'b1
   } fetch_state_t;

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc;
      logic        valid;
      logic        exc_adel;
   } fetch_out_t;

   // Last word address of the instruction window, wrapping on 32 bits.
   function automatic logic [31:0] window_last(input logic [31:0] base,
                                               input int unsigned words);
      logic [31:0] span;
      span = 32'(words) << 2;
      return base + span - PC_STEP;
   endfunction

   function automatic logic [31:0] sat_inc(input logic [31:0] value);
      return (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
   endfunction

endpackage

// File: rtl/im_fetch_ctrl_addr_check.sv
// Word-alignment and memory-window check for a byte address; shared by the
// fetch stage and the load/store unit.
module im_addr_check
   import im_fetch_ctrl_pkg::*;
#(
   parameter logic [31:0] BASE  = CPU_RESET_PC,
   parameter int unsigned WORDS = CPU_IM_WORDS
) (
   input  logic [31:0] pc,
   output logic        ok
);

   localparam logic [31:0] LAST = window_last(BASE, WORDS);

   logic aligned;
   logic above_base;
   logic below_last;

   assign aligned    = (pc[1:0] == 2'b00);
   assign above_base = (pc >= BASE);
   assign below_last = (pc <= LAST);
   assign ok         = aligned & above_base & below_last;

endmodule

// File: rtl/im_fetch_ctrl.sv
// Instruction fetch controller: drives the fetch PC, registers the fetched
// word for decode, and handles delay-slot redirects that may arrive during a stall.
module im_fetch_ctrl
   import im_fetch_ctrl_pkg::*;
#(
   parameter logic [31:0] RESET_PC = CPU_RESET_PC,
   parameter int unsigned IM_WORDS = CPU_IM_WORDS
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic        br_valid,
   input  logic [31:0] br_target,
   output logic [31:0] im_pc,
   input  logic [31:0] im_instr,
   output logic [31:0] instr_out,
   output logic [31:0] pc_out,
   output logic        valid_out,
   output logic        exc_adel,
   output logic [31:0] fetch_cnt
);

   logic [31:0]  pc_reg;
   fetch_state_t state_reg;
   logic         pend_reg;
   logic [31:0]  pend_target_reg;
   fetch_out_t   out_reg;
   logic [31:0]  fetch_cnt_reg;

   logic         fetch_ok;
   logic         redirect;
   logic [31:0]  redirect_target;
   logic [31:0]  pc_next;
   fetch_out_t   fetch_word;

   im_addr_check #(
      .BASE  (RESET_PC),
      .WORDS (IM_WORDS)
   ) u_addr_check (
      .pc (pc_reg),
      .ok (fetch_ok)
   );

   // A live br_valid is newer than anything latched during a stall.
   assign redirect        = br_valid | pend_reg;
   assign redirect_target = br_valid ? br_target : pend_target_reg;
   assign pc_next         = redirect ? redirect_target : pc_reg + PC_STEP;

   always_comb begin
      fetch_word          = '0;
      fetch_word.instr    = fetch_ok ? im_instr : INSTR_BUBBLE;
      fetch_word.pc       = pc_reg;
      fetch_word.valid    = 1'b1;
      fetch_word.exc_adel = ~fetch_ok;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pc_reg          <= RESET_PC;
         state_reg       <= FETCH_RUN;
         pend_reg        <= 1'b0;
         pend_target_reg <= '0;
         out_reg         <= '0;
         fetch_cnt_reg   <= '0;
      end else if (stall) begin
         if (br_valid) begin
            pend_reg        <= 1'b1;
            pend_target_reg <= br_target;
         end
      end else begin
         // The word fetched this cycle is always delivered: on a redirect it is the delay slot.
         out_reg       <= fetch_word;
         fetch_cnt_reg <= sat_inc(fetch_cnt_reg);
         pend_reg      <= 1'b0;
         pc_reg        <= pc_next;
         case (state_reg)
            FETCH_RUN: begin
               if (redirect) begin
                  state_reg <= FETCH_BUBBLE;
               end
            end
            FETCH_BUBBLE: begin
               if (!redirect) begin
                  state_reg <= FETCH_RUN;
               end
            end
            default: begin
               state_reg <= FETCH_RUN;
            end
         endcase
      end
   end

   assign im_pc     = pc_reg;
   assign instr_out = out_reg.instr;
   assign pc_out    = out_reg.pc;
   assign valid_out = out_reg.valid;
   assign exc_adel  = out_reg.exc_adel;
   assign fetch_cnt = fetch_cnt_reg;

endmodule

// File: tb/tb_im_fetch_ctrl.sv
// Self-checking bench for im_fetch_ctrl: directed scenarios plus random
// traffic compared every cycle against a behavioural fetch model.
module tb_im_fetch_ctrl;

   localparam logic [31:0]     RST_PC    = 32'h0000_3000;
   localparam longint unsigned WIN_BYTES = 64'd4 * 64'd65536;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        stall = 1'b0;
   logic        br_valid = 1'b0;
   logic [31:0] br_target = '0;
   logic [31:0] im_pc;
   logic [31:0] im_instr;
   logic [31:0] instr_out;
   logic [31:0] pc_out;
   logic        valid_out;
   logic        exc_adel;
   logic [31:0] fetch_cnt;

   int n_cmp  = 0;
   int n_fail = 0;

   // Behavioural model state
   logic [31:0] m_pc, m_ptgt, m_instr, m_pcout;
   longint unsigned m_cnt;
   bit          m_pend, m_valid, m_exc;

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
   endfunction

   function automatic bit in_range(input logic [31:0] a);
      longint unsigned v;
      v = 64'(a);
      return (v % 4 == 0) && (v >= 64'(RST_PC)) && (v <= 64'(RST_PC) + WIN_BYTES - 4);
   endfunction

   assign im_instr = mem_word(im_pc);

   im_fetch_ctrl dut (
      .clk       (clk),
      .reset     (reset),
      .stall     (stall),
      .br_valid  (br_valid),
      .br_target (br_target),
      .im_pc     (im_pc),
      .im_instr  (im_instr),
      .instr_out (instr_out),
      .pc_out    (pc_out),
      .valid_out (valid_out),
      .exc_adel  (exc_adel),
      .fetch_cnt (fetch_cnt)
   );

   wire [129:0] act_vec = {instr_out, pc_out, valid_out, exc_adel, fetch_cnt, im_pc};

   function automatic logic [129:0] exp_vec();
      logic [31:0] cnt32;
      cnt32 = (m_cnt > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : 32'(m_cnt);
      return {m_instr, m_pcout, m_valid, m_exc, cnt32, m_pc};
   endfunction

   // Drive one cycle of inputs, clock it, advance the model, settle past the edge.
   task automatic tick(input bit rst, input bit st, input bit bv, input logic [31:0] bt);
      bit ok;
      reset = rst; stall = st; br_valid = bv; br_target = bt;
      @(posedge clk);
      if (rst) begin
         m_pc = RST_PC; m_pend = 0; m_ptgt = 0;
         m_instr = 0; m_pcout = 0; m_valid = 0; m_exc = 0; m_cnt = 0;
      end else if (st) begin
         if (bv) begin
            m_pend = 1; m_ptgt = bt;
         end
      end else begin
         ok      = in_range(m_pc);
         m_instr = ok ? mem_word(m_pc) : 32'h0;
         m_pcout = m_pc;
         m_valid = 1;
         m_exc   = !ok;
         m_cnt   = m_cnt + 1;
         if (bv)          m_pc = bt;
         else if (m_pend) m_pc = m_ptgt;
         else             m_pc = m_pc + 32'd4;
         m_pend = 0;
      end
      #1;
   endtask

   task automatic test_reset();
      tick(1, 1, 1, 32'h3200);
      tick(1, 0, 0, 32'h0);
      n_cmp++;
      if (act_vec !== {32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h3000}) begin
         n_fail++;
         $display("FAIL reset_state: got %h want %h", act_vec,
                  {32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h3000});
      end
      n_cmp++;
      if (act_vec !== exp_vec()) begin
         n_fail++;
         $display("FAIL reset_model: got %h want %h", act_vec, exp_vec());
      end
   endtask

   task automatic test_sequential();
      logic [31:0] seq [3];
      seq = '{32'h3000, 32'h3004, 32'h3008};
      for (int i = 0; i < 3; i++) begin
         tick(0, 0, 0, 32'h0);
         n_cmp++;
         if (pc_out !== seq[i] || valid_out !== 1'b1 || fetch_cnt !== 32'(i + 1)
             || instr_out !== mem_word(seq[i]) || exc_adel !== 1'b0) begin
            n_fail++;
            $display("FAIL seq_%0d: got pc=%h v=%b cnt=%0d ins=%h exc=%b want pc=%h cnt=%0d ins=%h",
                     i, pc_out, valid_out, fetch_cnt, instr_out, exc_adel, seq[i], i + 1,
                     mem_word(seq[i]));
         end
      end
      $display("seq: pc_out=%h fetch_cnt=%0d", pc_out, fetch_cnt);
   endtask

   task automatic test_branch();
      logic [31:0] want [3];
      want = '{32'h3008, 32'h3100, 32'h3104};
      tick(1, 0, 0, 32'h0);
      tick(0, 0, 0, 32'h0);
      tick(0, 0, 0, 32'h0);
      for (int i = 0; i < 3; i++) begin
         tick(0, 0, (i == 0), 32'h3100);
         n_cmp++;
         if (pc_out !== want[i] || act_vec !== exp_vec()) begin
            n_fail++;
            $display("FAIL branch_%0d: got pc=%h vec=%h want pc=%h vec=%h",
                     i, pc_out, act_vec, want[i], exp_vec());
         end
      end
      $display("branch: pc_out=%h", pc_out);
   endtask

   task automatic test_stall_branch();
      logic [31:0] want [5];
      want = '{32'h3004, 32'h3004, 32'h3008, 32'h3200, 32'h3204};
      tick(1, 0, 0, 32'h0);
      tick(0, 0, 0, 32'h0);
      tick(0, 0, 0, 32'h0);
      for (int i = 0; i < 5; i++) begin
         tick(0, (i < 2), (i == 0), 32'h3200);
         n_cmp++;
         if (pc_out !== want[i] || act_vec !== exp_vec()) begin
            n_fail++;
            $display("FAIL stall_branch_%0d: got pc=%h vec=%h want pc=%h vec=%h",
                     i, pc_out, act_vec, want[i], exp_vec());
         end
      end
      $display("stall_branch: pc_out=%h cnt=%0d", pc_out, fetch_cnt);
   endtask

   task automatic test_double_pend();
      logic [31:0] want [5];
      logic [31:0] tgt  [5];
      want = '{32'h3000, 32'h3000, 32'h3004, 32'h3400, 32'h3404};
      tgt  = '{32'h3300, 32'h3400, 32'h0, 32'h0, 32'h0};
      tick(1, 0, 0, 32'h0);
      tick(0, 0, 0, 32'h0);
      for (int i = 0; i < 5; i++) begin
         tick(0, (i < 2), (i < 2), tgt[i]);
         n_cmp++;
         if (pc_out !== want[i] || pc_out === 32'h3300 || act_vec !== exp_vec()) begin
            n_fail++;
            $display("FAIL double_pend_%0d: got pc=%h vec=%h want pc=%h vec=%h",
                     i, pc_out, act_vec, want[i], exp_vec());
         end
      end
      $display("double_pend: pc_out=%h", pc_out);
   endtask

   task automatic test_bad_target();
      logic [31:0] tgts [5];
      bit          bad  [5];
      tgts = '{32'h0000_3002, 32'h0004_3000, 32'h0004_2FFC, 32'h0000_2FFC, 32'h0000_3000};
      bad  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
      tick(1, 0, 0, 32'h0);
      tick(0, 0, 0, 32'h0);
      for (int i = 0; i < 5; i++) begin
         tick(0, 0, 1, tgts[i]);
         tick(0, 0, 0, 32'h0);
         n_cmp++;
         if (pc_out !== tgts[i] || exc_adel !== bad[i] || valid_out !== 1'b1
             || instr_out !== (bad[i] ? 32'h0 : mem_word(tgts[i]))
             || act_vec !== exp_vec()) begin
            n_fail++;
            $display("FAIL bad_target_%0d: got pc=%h exc=%b ins=%h want pc=%h exc=%b",
                     i, pc_out, exc_adel, instr_out, tgts[i], bad[i]);
         end
      end
      $display("bad_target: last pc_out=%h exc=%b", pc_out, exc_adel);
   endtask

   task automatic test_reset_pend();
      tick(1, 0, 0, 32'h0);
      tick(0, 0, 0, 32'h0);
      tick(0, 1, 1, 32'h3200);
      tick(1, 0, 0, 32'h0);
      for (int i = 0; i < 4; i++) begin
         tick(0, 0, 0, 32'h0);
         n_cmp++;
         if (pc_out !== RST_PC + 32'(4 * i) || pc_out === 32'h3200 || act_vec !== exp_vec()) begin
            n_fail++;
            $display("FAIL reset_pend_%0d: got pc=%h vec=%h want pc=%h vec=%h",
                     i, pc_out, act_vec, RST_PC + 32'(4 * i), exp_vec());
         end
      end
      $display("reset_pend: pc_out=%h", pc_out);
   endtask

   task automatic test_random();
      logic [31:0] tgt;
      int          sel;
      int          bad_cnt;
      bad_cnt = 0;
      tick(1, 0, 0, 32'h0);
      for (int i = 0; i < 800; i++) begin
         sel = int'($urandom_range(0, 9));
         case (sel)
            0:       tgt = $urandom;
            1:       tgt = RST_PC + ($urandom_range(0, 65535) << 2) + $urandom_range(1, 3);
            2:       tgt = RST_PC + 32'h0003_FFF0 + ($urandom_range(0, 7) << 2);
            default: tgt = RST_PC + ($urandom_range(0, 65535) << 2);
         endcase
         tick(($urandom_range(0, 99) == 0), ($urandom_range(0, 2) == 0),
              ($urandom_range(0, 4) == 0), tgt);
         n_cmp++;
         if (act_vec !== exp_vec()) begin
            n_fail++;
            bad_cnt++;
            if (bad_cnt <= 10)
               $display("FAIL random_%0d: got %h want %h", i, act_vec, exp_vec());
         end
      end
      $display("random: final pc_out=%h fetch_cnt=%0d", pc_out, fetch_cnt);
   endtask

   initial begin
      test_reset();
      test_sequential();
      test_branch();
      test_stall_branch();
      test_double_pend();
      test_bad_target();
      test_reset_pend();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
